// File: rtl/serial_alu_sequencer_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: control codes, operation
// field encodings, FSM states and the packed view of the 4-bit control word.
package serial_alu_sequencer_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic       a_invert;
    logic       b_invert;
    logic [1:0] operation;
  } alu_ctrl_t;

endpackage

// File: rtl/serial_alu_sequencer_alu_top.sv
// One-bit ALU slice: optional operand inversion, then AND / OR / full-add / pass-less.
// The set output is the raw sum bit, used by the MSB slice for set-less-than.
module serial_alu_sequencer_alu_top
  import serial_alu_sequencer_pkg::*;
(
  input  logic       i_src1,
  input  logic       i_src2,
  input  logic       i_less,
  input  logic       i_a_invert,
  input  logic       i_b_invert,
  input  logic       i_cin,
  input  logic [1:0] i_operation,
  output logic       o_result,
  output logic       o_cout,
  output logic       o_set
);

  logic w_a;
  logic w_b;
  logic w_sum;

  always_comb begin
    w_a    = i_src1 ^ i_a_invert;
    w_b    = i_src2 ^ i_b_invert;
    w_sum  = w_a ^ w_b ^ i_cin;
    o_cout = (w_a & w_b) | (w_a & i_cin) | (w_b & i_cin);
    o_set  = w_sum;
    unique case (i_operation)
      OP_AND:  o_result = w_a & w_b;
      OP_OR:   o_result = w_a | w_b;
      OP_ADD:  o_result = w_sum;
      OP_SLT:  o_result = i_less;
      default: o_result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU front end: runs a WIDTH-bit operation LSB first through a single
// 1-bit slice, one bit per cycle, with valid/ready handshakes on both sides.
module serial_alu_sequencer
  import serial_alu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  alu_ctrl_t        r_ctrl;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_in_ready;

  logic             w_slice_res;
  logic             w_slice_cout;
  logic             w_slice_set;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res_final;

  serial_alu_sequencer_alu_top u_alu_top (
    .i_src1      (r_a[r_idx]),
    .i_src2      (r_b[r_idx]),
    .i_less      (1'b0),
    .i_a_invert  (r_ctrl.a_invert),
    .i_b_invert  (r_ctrl.b_invert),
    .i_cin       (r_carry),
    .i_operation (r_ctrl.operation),
    .o_result    (w_slice_res),
    .o_cout      (w_slice_cout),
    .o_set       (w_slice_set)
  );

  // Final-bit view: r_carry is still the carry into the MSB slice here.
  always_comb begin
    w_ovf       = r_carry ^ w_slice_cout;
    w_res_final = {w_slice_res, r_res[WIDTH-2:0]};
    if (r_ctrl.operation == OP_SLT) begin
      w_res_final    = '0;
      w_res_final[0] = w_slice_set ^ w_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_ctrl      <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_res       <= '0;
      r_zero      <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= src1;
            r_b        <= src2;
            r_ctrl     <= alu_ctrl_t'(ALU_control);
            r_idx      <= '0;
            r_carry    <= ALU_control[2];
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_carry <= w_slice_cout;
          if (r_idx == LastIdx) begin
            r_res       <= w_res_final;
            r_zero      <= ~|w_res_final;
            r_cout      <= r_ctrl.operation[1] & w_slice_cout;
            r_ovf       <= r_ctrl.operation[1] & w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_res[r_idx] <= w_slice_res;
            r_idx        <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_idx       <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready & ~rst;
  assign out_valid = r_out_valid;
  assign result    = r_res;
  assign zero      = r_zero;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: doc/serial_alu_sequencer.md
Name: serial_alu_sequencer

Overview:
Multi-cycle ALU front end that computes a WIDTH-bit operation one bit per cycle through a single `alu_top` 1-bit slice, LSB first. It holds the operands and control, feeds `src1`/`src2`/`cin`/`less` into the slice, and captures `result`/`cout`/`set` each cycle. It has valid/ready handshakes on both sides and is used where area matters more than latency.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- IDX_W, $clog2(WIDTH), width of the bit-index counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, request valid.
- in_ready, output, 1, sequencer can accept a request.
- src1, input, WIDTH, operand A.
- src2, input, WIDTH, operand B.
- ALU_control, input, 4, {A_invert, B_invert, operation[1:0]}.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- result, output, WIDTH, computed result.
- zero, output, 1, result == 0.
- cout, output, 1, carry out of the MSB slice.
- overflow, output, 1, signed overflow.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- Control decode is field-wise, so every code is legal:
  - operation 00 = AND, 01 = OR, 10 = ADD, 11 = SLT.
  - Standard codes: 0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt, 1100 nor.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch src1, src2, ALU_control; idx ← 0; carry ← B_invert; go to RUN.
- RUN, one slice evaluation per cycle, slice inputs:
  - src1 = a_q[idx], src2 = b_q[idx], cin = carry.
  - A_invert/B_invert/operation from the latched control.
  - less = 0.
- RUN, register updates each cycle:
  - res_q[idx] ← slice result; carry ← slice cout.
  - At idx = WIDTH-1, also record c_in_msb ← carry (pre-update), cout_q ← slice cout, set_q ← slice set.
  - Then go to DONE.
- DONE:
  - overflow = c_in_msb ^ cout_q when operation[1] = 1, else 0.
  - cout = cout_q when operation[1] = 1, else 0.
  - SLT fix-up, applied at the RUN→DONE edge: result[0] = set_q ^ overflow, result[WIDTH-1:1] = 0. This gives a correct signed compare.
  - zero = ~|result after the fix-up.
  - out_valid = 1; result/zero/cout/overflow held stable until out_ready.
  - On out_ready: go to IDLE.
- Latency: request accepted at edge T → out_valid high after edge T+WIDTH (WIDTH RUN cycles); back-to-back throughput is one op per WIDTH+2 cycles.
- in_ready = 0 in RUN and DONE; in_valid is ignored there and must not corrupt latched operands.
- Outputs are valid only while out_valid = 1. They are registered or derived purely from registers; nothing depends combinationally on the src* inputs.
- Reset, including mid-RUN or mid-DONE:
  - Next state IDLE; in-flight operation discarded.
  - out_valid = 0; result = 0; zero = 0; cout = 0; overflow = 0; idx = 0; carry = 0.
  - in_ready is forced 0 while rst is high.
- Index counter: never exceeds WIDTH-1; no wrap.

Decomposition:
- Shared include `alu_defs.vh`:
  - control codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR.
  - operation field encodings.
  - FSM state encodings S_IDLE, S_RUN, S_DONE.
- One sub-module: the existing `alu_top`, instantiated once and reused every cycle. No new sub-module.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 (ctrl 0010) → result 0x80000000, overflow 1, cout 0, zero 0; out_valid exactly WIDTH cycles after the accepting edge.
- SUB 5 − 5 (ctrl 0110) → result 0, zero 1, cout 1, overflow 0.
- SLT cases (ctrl 0111), each result with zero flag as shown:
  - 0xFFFFFFFF vs 0x00000001 → 0x00000001, zero 0.
  - 0x7FFFFFFF vs 0x80000000 → 0x00000000, zero 1 (overflow-corrected).
- Logic ops on 0xF0F0A5A5 and 0x0FF0FF00 (cout and overflow 0 for all):
  - AND → 0x00F0A500.
  - OR → 0xFFF0FFA5.
  - NOR (1100) → 0x000F005A.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid and toggle in_valid with new operands → outputs stable, in_ready 0, new operands not accepted; accepted on the first IDLE cycle after out_ready.
- Reset at idx = 10 of an ADD → next cycle state IDLE, out_valid 0, in_ready 1 after rst drops; a following ADD 3 + 4 returns 7 with correct latency.
